pipelined_comparator: RTL



---
 rtl/pipelined_comparator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipelined_comparator.sv
// Pipelined WIDTH-bit magnitude comparator, CHUNK bits resolved per stage MSB-first, valid/ready on both sides.
// Optional saturating result counters are enabled with the CMP_STATS_EN macro.
module pipelined_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             A_more_B,
    output logic             A_less_B
`ifdef CMP_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_lt
`endif
);

    localparam int STAGES = WIDTH / CHUNK;

    if ((WIDTH % CHUNK) != 0 || WIDTH < 4 || CNT_W < 1) begin : g_param_check
        $error("pipelined_comparator: illegal WIDTH/CHUNK/CNT_W");
    end

    logic             advance_s;
    logic [WIDTH-1:0] cap_a_s;
    logic [WIDTH-1:0] cap_b_s;

    // Stage k holds the state after chunks 0..k-1 have been examined; the
    // operand registers are shifted so the next chunk is always on top.
    logic             stg_valid_r [STAGES];
    logic             stg_dec_r   [STAGES];
    logic             stg_gt_r    [STAGES];
    logic [WIDTH-1:0] stg_a_r     [STAGES];
    logic [WIDTH-1:0] stg_b_r     [STAGES];
    logic             nxt_dec_s   [STAGES];
    logic             nxt_gt_s    [STAGES];

    logic             out_valid_r;
    logic             equal_r;
    logic             more_r;
    logic             less_r;

    assign advance_s = !out_valid_r || out_ready;
    assign in_ready  = advance_s;

    // Offset-binary conversion makes a signed compare an unsigned one.
    assign cap_a_s = {A[WIDTH-1] ^ is_signed, A[WIDTH-2:0]};
    assign cap_b_s = {B[WIDTH-1] ^ is_signed, B[WIDTH-2:0]};

    // Per-stage chunk decision: first differing chunk fixes the result.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_dec_s[k] = 1'b0;
            nxt_gt_s[k]  = 1'b0;
            if (stg_dec_r[k]) begin
                nxt_dec_s[k] = 1'b1;
                nxt_gt_s[k]  = stg_gt_r[k];
            end else begin
                nxt_dec_s[k] = (stg_a_r[k][WIDTH-1 -: CHUNK] != stg_b_r[k][WIDTH-1 -: CHUNK]);
                nxt_gt_s[k]  = (stg_a_r[k][WIDTH-1 -: CHUNK] >  stg_b_r[k][WIDTH-1 -: CHUNK]);
            end
        end
    end

    // Pipeline registers and registered result flags; all shift together on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stg_valid_r[k] <= 1'b0;
                stg_dec_r[k]   <= 1'b0;
                stg_gt_r[k]    <= 1'b0;
                stg_a_r[k]     <= {WIDTH{1'b0}};
                stg_b_r[k]     <= {WIDTH{1'b0}};
            end
            out_valid_r <= 1'b0;
            equal_r     <= 1'b0;
            more_r      <= 1'b0;
            less_r      <= 1'b0;
        end else if (advance_s) begin
            stg_valid_r[0] <= in_valid;
            stg_dec_r[0]   <= 1'b0;
            stg_gt_r[0]    <= 1'b0;
            stg_a_r[0]     <= in_valid ? cap_a_s : {WIDTH{1'b0}};
            stg_b_r[0]     <= in_valid ? cap_b_s : {WIDTH{1'b0}};
            for (int k = 1; k < STAGES; k++) begin
                stg_valid_r[k] <= stg_valid_r[k-1];
                stg_dec_r[k]   <= nxt_dec_s[k-1];
                stg_gt_r[k]    <= nxt_gt_s[k-1];
                stg_a_r[k]     <= stg_a_r[k-1] << CHUNK;
                stg_b_r[k]     <= stg_b_r[k-1] << CHUNK;
            end
            out_valid_r <= stg_valid_r[STAGES-1];
            equal_r     <= stg_valid_r[STAGES-1] & !nxt_dec_s[STAGES-1];
            more_r      <= stg_valid_r[STAGES-1] &  nxt_dec_s[STAGES-1] &  nxt_gt_s[STAGES-1];
            less_r      <= stg_valid_r[STAGES-1] &  nxt_dec_s[STAGES-1] & !nxt_gt_s[STAGES-1];
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign equal     = equal_r;
    assign A_more_B  = more_r;
    assign A_less_B  = less_r;

`ifdef CMP_STATS_EN
    logic [CNT_W-1:0] cnt_eq_r;
    logic [CNT_W-1:0] cnt_gt_r;
    logic [CNT_W-1:0] cnt_lt_r;
    logic             xfer_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign xfer_s = out_valid_r && out_ready;

    // Saturating result counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_eq_r <= {CNT_W{1'b0}};
            cnt_gt_r <= {CNT_W{1'b0}};
            cnt_lt_r <= {CNT_W{1'b0}};
        end else if (stats_clr) begin
            cnt_eq_r <= {CNT_W{1'b0}};
            cnt_gt_r <= {CNT_W{1'b0}};
            cnt_lt_r <= {CNT_W{1'b0}};
        end else if (xfer_s) begin
            cnt_eq_r <= equal_r ? sat_inc(cnt_eq_r) : cnt_eq_r;
            cnt_gt_r <= more_r  ? sat_inc(cnt_gt_r) : cnt_gt_r;
            cnt_lt_r <= less_r  ? sat_inc(cnt_lt_r) : cnt_lt_r;
        end else begin
            cnt_eq_r <= cnt_eq_r;
        end
    end

    assign cnt_eq = cnt_eq_r;
    assign cnt_gt = cnt_gt_r;
    assign cnt_lt = cnt_lt_r;
`endif

endmodule
